lsb_msg_extractor: RTL and testbench



---
 rtl/lsb_stego_pkg.sv | 34 +++
 rtl/lsb_bit_gather.sv | 16 +
 rtl/lsb_msg_extractor.sv | 141 ++++++++++++++
 tb/tb_lsb_msg_extractor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsb_stego_pkg.sv
// Shared types and helpers for the LSB steganography datapath.
// Used by both the message extractor and the embedder.
package lsb_stego_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [7:0] DELIM_DEFAULT = 8'h24;
    localparam int MAX_PIX_BYTES = 64;
    localparam int MAX_LSB_BITS  = 4;
    localparam int MAX_W = MAX_PIX_BYTES * MAX_LSB_BITS;

    // Extracted bit j*lsb_bits+i comes from bit i of channel byte j.
    function automatic logic [MAX_W-1:0] extract_lsbs(
        input logic [8*MAX_PIX_BYTES-1:0] word,
        input int                         pix_bytes,
        input int                         lsb_bits
    );
        logic [MAX_W-1:0] r;
        r = '0;
        for (int j = 0; j < MAX_PIX_BYTES; j++) begin
            for (int i = 0; i < MAX_LSB_BITS; i++) begin
                if (j < pix_bytes && i < lsb_bits)
                    r[j*lsb_bits+i] = word[8*j+i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lsb_bit_gather.sv
// Combinational gather of the low LSB_BITS of every channel byte.
// Channel byte 0 lands in the least significant bits.
module lsb_bit_gather #(
    parameter int PIX_BYTES = 16,
    parameter int LSB_BITS  = 1
) (
    input  logic [8*PIX_BYTES-1:0]        pix_data,
    output logic [PIX_BYTES*LSB_BITS-1:0] bits
);

    for (genvar j = 0; j < PIX_BYTES; j++) begin : g_ch
        assign bits[j*LSB_BITS +: LSB_BITS] =
            pix_data[8*j +: LSB_BITS];
    end

endmodule

// File: rtl/lsb_msg_extractor.sv
// Streaming LSB message decoder: pixel words in, message bytes out,
// stopping at the delimiter byte or after MAX_LEN bytes.
module lsb_msg_extractor
    import lsb_stego_pkg::*;
#(
    parameter int         PIX_BYTES = 16,
    parameter int         LSB_BITS  = 1,
    parameter logic [7:0] DELIM     = DELIM_DEFAULT,
    parameter int         MAX_LEN   = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [8*PIX_BYTES-1:0]       pix_data,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    output logic [7:0]                   msg_byte,
    output logic                         msg_valid,
    input  logic                         msg_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [$clog2(MAX_LEN+1)-1:0] msg_len
);

    localparam int W  = PIX_BYTES * LSB_BITS;
    localparam int NB = W / 8;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    if (W % 8 != 0) begin : g_bad_width
        $error("PIX_BYTES*LSB_BITS must be a multiple of 8");
    end
    if (LSB_BITS < 1 || LSB_BITS > 4) begin : g_bad_lsb
        $error("LSB_BITS must be in 1..4");
    end

    state_t          state;
    logic [W-1:0]    gathered;
    logic [W-1:0]    bits;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   nidx;
    logic            last;
    logic [7:0]      cand;
    logic [LW-1:0]   cnt;
    logic            go;
    logic            stop_delim;
    logic            stop_max;

    lsb_bit_gather #(
        .PIX_BYTES (PIX_BYTES),
        .LSB_BITS  (LSB_BITS)
    ) u_gather (
        .pix_data (pix_data),
        .bits     (gathered)
    );

    // cand/cnt describe the byte that would be presented next cycle.
    always_comb begin
        last = (idx == IW'(NB - 1));
        nidx = last ? '0 : idx + 1'b1;
        cand = '0;
        cnt  = msg_len;
        if (state == S_LOAD) begin
            cand = gathered[7:0];
            cnt  = msg_len;
        end else begin
            cand = bits[8*nidx +: 8];
            cnt  = msg_len + 1'b1;
        end
        stop_delim = (cand == DELIM);
        stop_max   = (cnt == LW'(MAX_LEN));
        go = (state == S_LOAD && pix_valid) ||
             (state == S_EMIT && msg_valid &&
              msg_ready && !last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bits      <= '0;
            idx       <= '0;
            pix_ready <= 1'b0;
            msg_byte  <= '0;
            msg_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            msg_len   <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        overflow  <= 1'b0;
                        msg_len   <= '0;
                    end
                end
                S_LOAD: begin
                    if (pix_valid) begin
                        bits      <= gathered;
                        idx       <= '0;
                        pix_ready <= 1'b0;
                    end
                end
                S_EMIT: begin
                    if (msg_valid && msg_ready) begin
                        msg_len <= cnt;
                        if (last) begin
                            state     <= S_LOAD;
                            pix_ready <= 1'b1;
                            msg_valid <= 1'b0;
                        end else begin
                            idx <= nidx;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (go) begin
                if (stop_delim || stop_max) begin
                    state     <= S_DONE;
                    done      <= 1'b1;
                    overflow  <= !stop_delim;
                    msg_valid <= 1'b0;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                end else begin
                    state     <= S_EMIT;
                    msg_valid <= 1'b1;
                    msg_byte  <= cand;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsb_msg_extractor.sv
// Scoreboard bench for lsb_msg_extractor with three parameter sets:
// defaults, MAX_LEN=3, and PIX_BYTES=8/LSB_BITS=2.
module tb_lsb_msg_extractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // dut0: defaults
    logic         start0 = 0, pix_valid0 = 0, msg_ready0 = 1;
    logic [127:0] pix_data0 = '0;
    logic         pix_ready0, msg_valid0, busy0, done0, overflow0;
    logic [7:0]   msg_byte0;
    logic [10:0]  msg_len0;

    // dut1: MAX_LEN=3
    logic         start1 = 0, pix_valid1 = 0, msg_ready1 = 1;
    logic [127:0] pix_data1 = '0;
    logic         pix_ready1, msg_valid1, busy1, done1, overflow1;
    logic [7:0]   msg_byte1;
    logic [1:0]   msg_len1;

    // dut2: PIX_BYTES=8, LSB_BITS=2
    logic         start2 = 0, pix_valid2 = 0, msg_ready2 = 1;
    logic [63:0]  pix_data2 = '0;
    logic         pix_ready2, msg_valid2, busy2, done2, overflow2;
    logic [7:0]   msg_byte2;
    logic [10:0]  msg_len2;

    lsb_msg_extractor dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .pix_data(pix_data0), .pix_valid(pix_valid0),
        .pix_ready(pix_ready0), .msg_byte(msg_byte0),
        .msg_valid(msg_valid0), .msg_ready(msg_ready0),
        .busy(busy0), .done(done0), .overflow(overflow0),
        .msg_len(msg_len0)
    );

    lsb_msg_extractor #(.MAX_LEN(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .pix_data(pix_data1), .pix_valid(pix_valid1),
        .pix_ready(pix_ready1), .msg_byte(msg_byte1),
        .msg_valid(msg_valid1), .msg_ready(msg_ready1),
        .busy(busy1), .done(done1), .overflow(overflow1),
        .msg_len(msg_len1)
    );

    lsb_msg_extractor #(.PIX_BYTES(8), .LSB_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .pix_data(pix_data2), .pix_valid(pix_valid2),
        .pix_ready(pix_ready2), .msg_byte(msg_byte2),
        .msg_valid(msg_valid2), .msg_ready(msg_ready2),
        .busy(busy2), .done(done2), .overflow(overflow2),
        .msg_len(msg_len2)
    );

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic sb(input int id, input logic [7:0] got,
                      inout logic [7:0] q[$]);
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL sb%0d: got %h want none", id, got);
        end else begin
            logic [7:0] e;
            e = q.pop_front();
            if (got !== e) begin
                bad++;
                $display("FAIL sb%0d: got %h want %h", id, got, e);
            end
        end
    endtask

    always @(negedge clk)
        if (rst_n && msg_valid0 && msg_ready0) sb(0, msg_byte0, q0);
    always @(negedge clk)
        if (rst_n && msg_valid1 && msg_ready1) sb(1, msg_byte1, q1);
    always @(negedge clk)
        if (rst_n && msg_valid2 && msg_ready2) sb(2, msg_byte2, q2);

    // LSB of channel k carries bit k of {b, a}; upper bits are filler.
    function automatic logic [127:0] enc16(input logic [7:0] a,
                                           input logic [7:0] b);
        logic [15:0]  m;
        logic [127:0] r;
        m = {b, a};
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = (8'(k * 37) & 8'hFE) | {7'b0, m[k]};
        return r;
    endfunction

    // Low 2 bits of channel k carry f[2k+1:2k].
    function automatic logic [63:0] enc8(input logic [15:0] f);
        logic [63:0] r;
        for (int k = 0; k < 8; k++)
            r[8*k +: 8] = (8'(k * 53) & 8'hFC) | {6'b0, f[2*k +: 2]};
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [15:0] lv;
        repeat (3) cyc();
        rst_n = 1'b1;

        // reset state
        chk("rst pix_ready", 32'(pix_ready0), 0);
        chk("rst msg_valid", 32'(msg_valid0), 0);
        chk("rst msg_byte", 32'(msg_byte0), 0);
        chk("rst busy", 32'(busy0), 0);
        chk("rst done/ovf", 32'({done0, overflow0}), 0);
        chk("rst msg_len", 32'(msg_len0), 0);

        // basic decode with exact timing
        start0 = 1; cyc(); start0 = 0;
        chk("start pix_ready", 32'(pix_ready0), 1);
        chk("start busy", 32'(busy0), 1);
        pix_data0 = enc16(8'h48, 8'h69);
        q0.push_back(8'h48); q0.push_back(8'h69);
        pix_valid0 = 1; cyc(); pix_valid0 = 0;
        chk("N+1 byte", 32'({msg_valid0, msg_byte0}), 32'h148);
        cyc();
        chk("N+2 byte", 32'({msg_valid0, msg_byte0}), 32'h169);
        cyc();
        chk("N+3 pix_ready", 32'(pix_ready0), 1);
        chk("N+3 msg_len", 32'(msg_len0), 2);

        // delimiter stops the decode
        pix_data0 = enc16(8'h21, 8'h24);
        q0.push_back(8'h21);
        pix_valid0 = 1; cyc(); pix_valid0 = 0;
        chk("delim byte", 32'({msg_valid0, msg_byte0}), 32'h121);
        cyc();
        chk("delim done", 32'({done0, overflow0}), 32'b10);
        chk("delim msg_len", 32'(msg_len0), 3);
        chk("delim valid", 32'(msg_valid0), 0);
        pix_valid0 = 1;
        for (int i = 0; i < 3; i++) begin
            chk("done pix_ready", 32'(pix_ready0), 0);
            cyc();
        end
        pix_valid0 = 0;

        // backpressure
        msg_ready0 = 0;
        start0 = 1; cyc(); start0 = 0;
        chk("restart done", 32'(done0), 0);
        chk("restart msg_len", 32'(msg_len0), 0);
        pix_data0 = enc16(8'h48, 8'h69);
        q0.push_back(8'h48); q0.push_back(8'h69);
        pix_valid0 = 1; cyc(); pix_valid0 = 0;
        for (int i = 0; i < 5; i++) begin
            chk("hold", 32'({msg_valid0, msg_byte0,
                             pix_ready0, msg_len0}),
                32'({1'b1, 8'h48, 1'b0, 11'd0}));
            cyc();
        end
        msg_ready0 = 1; cyc();
        chk("release len", 32'(msg_len0), 1);
        chk("release byte", 32'(msg_byte0), 32'h69);
        cyc();
        chk("release end", 32'({pix_ready0, msg_len0}),
            32'({1'b1, 11'd2}));

        // overflow with MAX_LEN=3
        start1 = 1; cyc(); start1 = 0;
        pix_data1 = enc16(8'h41, 8'h42);
        q1.push_back(8'h41); q1.push_back(8'h42);
        pix_valid1 = 1; cyc(); pix_valid1 = 0;
        n = 0;
        while (!pix_ready1 && n < 20) begin cyc(); n++; end
        chk("ovf reload", 32'(pix_ready1), 1);
        pix_data1 = enc16(8'h43, 8'h44);
        q1.push_back(8'h43);
        pix_valid1 = 1; cyc(); pix_valid1 = 0;
        repeat (3) cyc();
        chk("ovf flags", 32'({done1, overflow1, busy1}), 32'b110);
        chk("ovf msg_len", 32'(msg_len1), 3);
        chk("ovf valid", 32'(msg_valid1), 0);

        // PIX_BYTES=8, LSB_BITS=2: fields 0,1,2,3,3,2,1,0
        start2 = 1; cyc(); start2 = 0;
        lv = {2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        pix_data2 = enc8(lv);
        q2.push_back(8'hE4); q2.push_back(8'h1B);
        pix_valid2 = 1; cyc(); pix_valid2 = 0;
        chk("p2 byte0", 32'({msg_valid2, msg_byte2}), 32'h1E4);
        n = 0;
        while (!pix_ready2 && n < 20) begin cyc(); n++; end
        chk("p2 reload", 32'(pix_ready2), 1);
        // 0x24 then 0x55 as 2-bit fields, low first
        lv = {2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
        pix_data2 = enc8(lv);
        pix_valid2 = 1; cyc(); pix_valid2 = 0;
        chk("p2 done", 32'({done2, overflow2, msg_valid2}), 32'b100);
        chk("p2 msg_len", 32'(msg_len2), 2);
        start2 = 1; cyc(); start2 = 0;
        chk("p2 restart", 32'({done2, busy2, msg_len2}),
            32'({1'b0, 1'b1, 11'd0}));

        // reset in the middle of EMIT with msg_valid high
        msg_ready0 = 0;
        start0 = 1; cyc(); start0 = 0;
        pix_data0 = enc16(8'h41, 8'h42);
        pix_valid0 = 1; cyc(); pix_valid0 = 0;
        chk("pre-rst valid", 32'(msg_valid0), 1);
        rst_n = 0; cyc(); rst_n = 1;
        chk("mid-rst outs", 32'({msg_valid0, pix_ready0,
                                 busy0, done0, msg_len0}), 0);
        cyc();
        chk("mid-rst idle", 32'({pix_ready0, busy0}), 0);
        msg_ready0 = 1;
        repeat (3) cyc();

        chk("q0 drained", 32'(q0.size()), 0);
        chk("q1 drained", 32'(q1.size()), 0);
        chk("q2 drained", 32'(q2.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
